// File: rtl/rf_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving a 4x8 register file.
// Optional retired-instruction counter enabled by defining RF_SEQ_RETIRE_CNT_EN.
module rf_seq_ctrl #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic            rf_we,
    output logic [1:0]      rf_rd,
    output logic [1:0]      rf_rs1,
    output logic [1:0]      rf_rs2,
    output logic [7:0]      rf_wd,
    input  logic [7:0]      rf_rs1_out,
    input  logic [7:0]      rf_rs2_out,
    output logic            busy,
    output logic            halted,
    output logic            zero,
    output logic [15:0]     instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IMM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_SPEC = 2'b11;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [7:0]      ir, ir_nxt;
    logic [7:0]      result, result_nxt;
    logic            zero_nxt;

    logic [1:0] op;
    assign op = ir[7:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= START_ADDR;
            ir     <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            ir     <= ir_nxt;
            result <= result_nxt;
            zero   <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        result_nxt = result;
        zero_nxt   = zero;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = START_ADDR;
                end
            end
            S_FETCH: begin
                ir_nxt    = imem_data;
                pc_nxt    = pc + PC_W'(1);
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_SPEC) begin
                    case (ir[1:0])
                        2'b00:   state_nxt = S_IMM;
                        2'b11:   state_nxt = S_HALT;
                        default: state_nxt = S_FETCH;
                    endcase
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ADD:  result_nxt = rf_rs1_out + rf_rs2_out;
                    OP_SUB:  result_nxt = rf_rs1_out - rf_rs2_out;
                    OP_AND:  result_nxt = rf_rs1_out & rf_rs2_out;
                    default: result_nxt = result;
                endcase
                state_nxt = S_WB;
            end
            S_IMM: begin
                result_nxt = imem_data;
                pc_nxt     = pc + PC_W'(1);
                state_nxt  = S_WB;
            end
            S_WB: begin
                zero_nxt  = (result == 8'h00);
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write strobe is decoded straight from state so an async reset drops it at once
    assign rf_we     = (state == S_WB);
    assign busy      = state inside {S_FETCH, S_DECODE, S_EXEC, S_IMM, S_WB};
    assign halted    = (state == S_HALT);
    assign imem_addr = pc;
    assign rf_rd     = ir[5:4];
    assign rf_rs1    = ir[3:2];
    assign rf_rs2    = ir[1:0];
    assign rf_wd     = result;

`ifdef RF_SEQ_RETIRE_CNT_EN
    logic        retire;
    logic [15:0] cnt;

    // NOPs retire straight out of DECODE; HALT never retires
    assign retire = (state == S_WB) ||
                    (state == S_DECODE && op == OP_SPEC &&
                     (ir[1:0] == 2'b01 || ir[1:0] == 2'b10));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (retire) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign instr_count = cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Self-checking bench for rf_seq_ctrl: ISA-level timeline model checked every cycle.
module tb_rf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr, imem_data;
    logic        rf_we;
    logic [1:0]  rf_rd, rf_rs1, rf_rs2;
    logic [7:0]  rf_wd, rf_rs1_out, rf_rs2_out;
    logic        busy, halted, zero;
    logic [15:0] instr_count;

    logic        start2 = 1'b0;
    logic [7:0]  imem_addr2, imem_data2;
    logic        rf_we2;
    logic [1:0]  rf_rd2, rf_rs12, rf_rs22;
    logic [7:0]  rf_wd2;
    logic        busy2, halted2, zero2;
    logic [15:0] instr_count2;

    logic [7:0] imem  [256];
    logic [7:0] imem2 [256];
    logic [7:0] rf    [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_seq_ctrl #(.PC_W(8), .START_ADDR(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_wd(rf_wd), .rf_rs1_out(rf_rs1_out), .rf_rs2_out(rf_rs2_out),
        .busy(busy), .halted(halted), .zero(zero), .instr_count(instr_count)
    );

    rf_seq_ctrl #(.PC_W(8), .START_ADDR(8'hFF)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .rf_we(rf_we2), .rf_rd(rf_rd2), .rf_rs1(rf_rs12), .rf_rs2(rf_rs22),
        .rf_wd(rf_wd2), .rf_rs1_out(8'h00), .rf_rs2_out(8'h00),
        .busy(busy2), .halted(halted2), .zero(zero2), .instr_count(instr_count2)
    );

    assign imem_data  = imem[imem_addr];
    assign imem_data2 = imem2[imem_addr2];
    assign rf_rs1_out = rf[rf_rs1];
    assign rf_rs2_out = rf[rf_rs2];

    always @(posedge clk) if (rf_we) rf[rf_rd] <= rf_wd;

    // Architectural model state
    typedef struct {
        logic       busy, halted, we, zero;
        logic [1:0] rd;
        logic [7:0] wd, addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [7:0]  m_regs [4];
    logic        m_zero = 1'b0;
    logic [15:0] m_cnt = '0;
    int          halt_idx;

    function automatic void push(input logic b, input logic h, input logic w,
                                 input logic z, input logic [1:0] rd,
                                 input logic [7:0] wd, input logic [7:0] addr);
        exp_t e;
        e.busy = b; e.halted = h; e.we = w; e.zero = z;
        e.rd = rd; e.wd = wd; e.addr = addr;
        exp_q.push_back(e);
    endfunction

    // Expand the program into a per-cycle timeline from instruction latencies
    task automatic build();
        logic [7:0] pc, ir, a, val;
        logic [1:0] op, rd, s1, s2;
        pc = 8'h00;
        halt_idx = -1;
        for (int n = 0; n < 64; n++) begin
            ir = imem[pc]; op = ir[7:6]; rd = ir[5:4]; s1 = ir[3:2]; s2 = ir[1:0];
            a = pc + 8'd1;
            push(1, 0, 0, m_zero, 0, 0, pc);
            if (op == 2'b11 && s2 == 2'b11) begin
                push(1, 0, 0, m_zero, 0, 0, a);
                halt_idx = exp_q.size();
                for (int k = 0; k < 3; k++) push(0, 1, 0, m_zero, 0, 0, a);
                break;
            end else if (op == 2'b11 && s2 != 2'b00) begin
                push(1, 0, 0, m_zero, 0, 0, a);
                m_cnt++;
                pc = a;
            end else if (op == 2'b11) begin
                push(1, 0, 0, m_zero, 0, 0, a);
                push(1, 0, 0, m_zero, 0, 0, a);
                val = imem[a];
                pc = a + 8'd1;
                push(1, 0, 1, m_zero, rd, val, pc);
                m_zero = (val == 8'h00);
                m_regs[rd] = val;
                m_cnt++;
            end else begin
                case (op)
                    2'b00:   val = m_regs[s1] + m_regs[s2];
                    2'b01:   val = m_regs[s1] - m_regs[s2];
                    default: val = m_regs[s1] & m_regs[s2];
                endcase
                push(1, 0, 0, m_zero, 0, 0, a);
                push(1, 0, 0, m_zero, 0, 0, a);
                push(1, 0, 1, m_zero, rd, val, a);
                m_zero = (val == 8'h00);
                m_regs[rd] = val;
                m_cnt++;
                pc = a;
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (busy !== cur.busy || halted !== cur.halted || rf_we !== cur.we ||
                zero !== cur.zero || imem_addr !== cur.addr ||
                (cur.we && (rf_rd !== cur.rd || rf_wd !== cur.wd))) begin
                errors++;
                $display("FAIL cycle t=%0t: got busy=%b halted=%b we=%b zero=%b addr=%h rd=%0d wd=%h, want busy=%b halted=%b we=%b zero=%b addr=%h rd=%0d wd=%h",
                         $time, busy, halted, rf_we, zero, imem_addr, rf_rd, rf_wd,
                         cur.busy, cur.halted, cur.we, cur.zero, cur.addr, cur.rd, cur.wd);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic load(input logic [7:0] p[$]);
        for (int i = 0; i < 256; i++) imem[i] = 8'hC3;
        for (int i = 0; i < p.size(); i++) imem[i] = p[i];
    endtask

    task automatic run(input int inj);
        @(negedge clk);
        #1 start = 1'b1;
        build();
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            if (i == inj) begin
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d timeline cycles left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [15:0] cnt_want();
`ifdef RF_SEQ_RETIRE_CNT_EN
        return m_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    initial begin
        logic [7:0] prog[$];
        logic [7:0] exp_a [5];
        logic       exp_h [5];

        for (int i = 0; i < 4; i++) begin rf[i] = 8'h00; m_regs[i] = 8'h00; end
        for (int i = 0; i < 256; i++) imem2[i] = 8'hC3;
        imem2[8'hFF] = 8'hC1;
        prog = {8'hD0, 8'h05, 8'hE0, 8'h03, 8'h36, 8'hC3};
        load(prog);

        #12;
        check("reset busy", {15'd0, busy}, 16'h0);
        check("reset halted", {15'd0, halted}, 16'h0);
        check("reset rf_we", {15'd0, rf_we}, 16'h0);
        check("reset zero", {15'd0, zero}, 16'h0);
        check("reset imem_addr", {8'd0, imem_addr}, 16'h00);
        check("reset rf_wd", {8'd0, rf_wd}, 16'h00);
        check("reset instr_count", instr_count, 16'h0000);
        rst_n = 1'b1;

        // LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT
        run(-1);
        check("model halt latency", 16'(halt_idx), 16'd14);
        check("model r3", {8'd0, m_regs[3]}, 16'h08);
        check("prog1 r1", {8'd0, rf[1]}, 16'h05);
        check("prog1 r2", {8'd0, rf[2]}, 16'h03);
        check("prog1 r3", {8'd0, rf[3]}, 16'h08);
        check("prog1 halted", {15'd0, halted}, 16'h1);
`ifdef RF_SEQ_RETIRE_CNT_EN
        check("prog1 instr_count", instr_count, 16'd3);
`else
        check("prog1 instr_count", instr_count, 16'd0);
`endif

        // SUB r0,r1,r2 with 3-5
        prog = {8'hD0, 8'h03, 8'hE0, 8'h05, 8'h46, 8'hC3};
        load(prog);
        run(-1);
        check("sub r0", {8'd0, rf[0]}, 16'h00FE);
        check("sub zero", {15'd0, zero}, 16'h0);

        // AND r3,r1,r2 with F0&0F, then NOP, HALT
        prog = {8'hD0, 8'hF0, 8'hE0, 8'h0F, 8'hB6, 8'hC1, 8'hC3};
        load(prog);
        run(-1);
        check("and r3", {8'd0, rf[3]}, 16'h00);
        check("and zero", {15'd0, zero}, 16'h1);
        check("count after nop", instr_count, cnt_want());

        // Reset asserted in the middle of WB of LDI r1,AA
        prog = {8'hD0, 8'hAA, 8'hC3};
        load(prog);
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("wb reached", {15'd0, rf_we}, 16'h1);
        rst_n = 1'b0;
        #1;
        check("rf_we async drop", {15'd0, rf_we}, 16'h0);
        @(posedge clk);
        #1;
        check("no write in reset", {8'd0, rf[1]}, 16'h00F0);
        check("post-reset busy", {15'd0, busy}, 16'h0);
        check("post-reset pc", {8'd0, imem_addr}, 16'h00);
        check("post-reset count", instr_count, 16'h0000);
        m_cnt = '0;
        m_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Start pulse while busy is ignored; start from HALT restarts cleanly
        prog = {8'hD0, 8'h05, 8'hE0, 8'h03, 8'h36, 8'hC3};
        load(prog);
        run(3);
        run(-1);
        check("restart r3", {8'd0, rf[3]}, 16'h08);
        check("restart count", instr_count, cnt_want());

        // PC wrap: NOP at FF, HALT at 00, START_ADDR=FF
        exp_a = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
        exp_h = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        #1 start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wrap addr", {8'd0, imem_addr2}, {8'd0, exp_a[i]});
            check("wrap halted", {15'd0, halted2}, {15'd0, exp_h[i]});
        end
`ifdef RF_SEQ_RETIRE_CNT_EN
        check("wrap count", instr_count2, 16'd1);
`else
        check("wrap count", instr_count2, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
